// File: rtl/xc20xx_cfgload.sv
// xc20xx_cfgload: serial configuration loader for the XC20XX CLB array.
// Parses preamble, length and 43-bit frames from DIN (sampled when DIN_EN=1)
// and emits one checked 40-bit configuration word per CLB.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for the first preamble 0 on idle '1's
// S_PRE    | checking the remaining preamble bits 0,1,0
// S_LEN    | shifting in the 8-bit frame count, LSB first
// S_FSTART | expecting a frame start bit (0)
// S_FDATA  | shifting in 40 data bits, LSB first
// S_FPAR   | checking even parity over data + parity bit
// S_FSTOP  | checking stop bit and field legality, accepting the frame
// S_DONE   | all frames loaded, absorbing
// S_ERROR  | load aborted, absorbing
module xc20xx_cfgload #(
    parameter int NUM_FRAMES = 64
) (
    input  logic        K,
    input  logic        RST,
    input  logic        DIN,
    input  logic        DIN_EN,
    output logic [39:0] CFG_WORD,
    output logic [7:0]  CFG_ADDR,
    output logic        CFG_STB,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [2:0]  ERR_CODE
);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_LEN, S_FSTART, S_FDATA, S_FPAR, S_FSTOP, S_DONE, S_ERROR
    } state_t;

    localparam logic [8:0] MAX_LEN = 9'(NUM_FRAMES);

    state_t      state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [39:0] shift_q, shift_d;
    logic [39:0] cfg_word_q, cfg_word_d;
    logic [7:0]  cfg_addr_q, cfg_addr_d;
    logic        cfg_stb_q, cfg_stb_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [2:0]  err_code_q, err_code_d;
    logic [7:0]  len_next;
    logic        field_bad;

    // Any 2-bit mux field set to the unused encoding, or reserved bits set
    always_comb begin
        field_bad = (shift_q[19:18] == 2'b11) || (shift_q[23:22] == 2'b11) ||
                    (shift_q[26:25] == 2'b11) || (shift_q[28:27] == 2'b11) ||
                    (shift_q[30:29] == 2'b11) || (shift_q[32:31] == 2'b11) ||
                    (shift_q[34:33] == 2'b11) || (shift_q[37:36] == 2'b11) ||
                    (shift_q[39:38] != 2'b00);
    end

    // Next-state and output decode; everything holds unless DIN_EN samples a bit
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        len_d       = len_q;
        frame_cnt_d = frame_cnt_q;
        shift_d     = shift_q;
        cfg_word_d  = cfg_word_q;
        cfg_addr_d  = cfg_addr_q;
        cfg_stb_d   = 1'b0;
        err_code_d  = err_code_q;
        len_next    = {DIN, len_q[7:1]};

        if (DIN_EN) begin
            case (state_q)
                S_IDLE: begin
                    if (!DIN) begin
                        state_d   = S_PRE;
                        bit_cnt_d = '0;
                    end
                end
                S_PRE: begin
                    if (DIN != (bit_cnt_q == 6'd1)) begin
                        state_d    = S_ERROR;
                        err_code_d = 3'd1;
                    end else if (bit_cnt_q == 6'd2) begin
                        state_d   = S_LEN;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                S_LEN: begin
                    len_d = len_next;
                    if (bit_cnt_q == 6'd7) begin
                        bit_cnt_d = '0;
                        if (len_next == 8'd0 || {1'b0, len_next} > MAX_LEN) begin
                            state_d    = S_ERROR;
                            err_code_d = 3'd2;
                        end else begin
                            state_d = S_FSTART;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                S_FSTART: begin
                    if (DIN) begin
                        state_d    = S_ERROR;
                        err_code_d = 3'd3;
                    end else begin
                        state_d   = S_FDATA;
                        bit_cnt_d = '0;
                    end
                end
                S_FDATA: begin
                    shift_d = {DIN, shift_q[39:1]};
                    if (bit_cnt_q == 6'd39) begin
                        state_d   = S_FPAR;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                S_FPAR: begin
                    if ((^shift_q) ^ DIN) begin
                        state_d    = S_ERROR;
                        err_code_d = 3'd4;
                    end else begin
                        state_d = S_FSTOP;
                    end
                end
                S_FSTOP: begin
                    if (!DIN) begin
                        state_d    = S_ERROR;
                        err_code_d = 3'd3;
                    end else if (field_bad) begin
                        state_d    = S_ERROR;
                        err_code_d = 3'd5;
                    end else begin
                        cfg_word_d  = shift_q;
                        cfg_addr_d  = frame_cnt_q;
                        cfg_stb_d   = 1'b1;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        state_d     = (frame_cnt_q == len_q - 8'd1) ? S_DONE : S_FSTART;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        busy_d = (state_d == S_PRE) || (state_d == S_LEN) || (state_d == S_FSTART) ||
                 (state_d == S_FDATA) || (state_d == S_FPAR) || (state_d == S_FSTOP);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERROR);
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge K) begin
        if (RST) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            len_q       <= '0;
            frame_cnt_q <= '0;
            shift_q     <= '0;
            cfg_word_q  <= '0;
            cfg_addr_q  <= '0;
            cfg_stb_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            len_q       <= len_d;
            frame_cnt_q <= frame_cnt_d;
            shift_q     <= shift_d;
            cfg_word_q  <= cfg_word_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_stb_q   <= cfg_stb_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign CFG_WORD = cfg_word_q;
    assign CFG_ADDR = cfg_addr_q;
    assign CFG_STB  = cfg_stb_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign ERR_CODE = err_code_q;

endmodule

// File: tb/tb_xc20xx_cfgload.sv
// Bench for xc20xx_cfgload: streams are built as bit queues, a positional
// parser predicts every accept/error by bit index, and outputs are compared
// against that prediction on every falling edge.
module tb_xc20xx_cfgload;

    localparam int NF  = 64;
    localparam int BIG = 1 << 30;

    logic        K = 1'b0;
    logic        RST = 1'b1;
    logic        DIN = 1'b1;
    logic        DIN_EN = 1'b0;
    logic [39:0] CFG_WORD;
    logic [7:0]  CFG_ADDR;
    logic        CFG_STB, BUSY, DONE, ERR;
    logic [2:0]  ERR_CODE;

    xc20xx_cfgload #(.NUM_FRAMES(NF)) dut (
        .K(K), .RST(RST), .DIN(DIN), .DIN_EN(DIN_EN),
        .CFG_WORD(CFG_WORD), .CFG_ADDR(CFG_ADDR), .CFG_STB(CFG_STB),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_CODE(ERR_CODE)
    );

    always #5 K = ~K;

    bit          sq[$];
    int          acc_idx[$];
    logic [39:0] acc_word[$];
    int          fail_idx, fail_code, done_idx, i0;
    int          m, last_idx;
    int          checks = 0, errors = 0;
    bit          chk_on = 0;
    int          stb_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit illegal(input logic [39:0] w);
        int pos[8] = '{18, 22, 25, 27, 29, 31, 33, 36};
        bit bad;
        bad = (w[39:38] != 2'b00);
        for (int k = 0; k < 8; k++)
            if (w[pos[k] +: 2] == 2'b11) bad = 1;
        return bad;
    endfunction

    // Positional parser: which bit index accepts which frame, where the load fails
    function automatic void analyze();
        int p, len, base;
        logic [39:0] w;
        fail_idx = BIG; fail_code = 0; done_idx = BIG;
        acc_idx.delete(); acc_word.delete();
        i0 = 0;
        while (i0 < sq.size() && sq[i0] == 1'b1) i0++;
        if (i0 >= sq.size()) return;
        for (int k = 1; k <= 3; k++) begin
            p = i0 + k;
            if (p >= sq.size()) return;
            if (sq[p] != (k == 2)) begin fail_idx = p; fail_code = 1; return; end
        end
        len = 0;
        for (int b = 0; b < 8; b++) begin
            p = i0 + 4 + b;
            if (p >= sq.size()) return;
            len += int'(sq[p]) << b;
        end
        if (len == 0 || len > NF) begin fail_idx = i0 + 11; fail_code = 2; return; end
        for (int f = 0; f < len; f++) begin
            base = i0 + 12 + 43 * f;
            if (base >= sq.size()) return;
            if (sq[base] != 1'b0) begin fail_idx = base; fail_code = 3; return; end
            if (base + 40 >= sq.size()) return;
            for (int b = 0; b < 40; b++) w[b] = sq[base + 1 + b];
            if (base + 41 >= sq.size()) return;
            if (((^w) ^ sq[base + 41]) != 1'b0) begin fail_idx = base + 41; fail_code = 4; return; end
            if (base + 42 >= sq.size()) return;
            if (sq[base + 42] == 1'b0) begin fail_idx = base + 42; fail_code = 3; return; end
            if (illegal(w)) begin fail_idx = base + 42; fail_code = 5; return; end
            acc_idx.push_back(base + 42);
            acc_word.push_back(w);
            if (f == len - 1) done_idx = base + 42;
        end
    endfunction

    task automatic push_bits(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) sq.push_back(v[i]);
    endtask

    task automatic push_header(input int idle, input int len);
        for (int i = 0; i < idle; i++) sq.push_back(1'b1);
        push_bits(64'b0100, 4);   // 0,0,1,0 in send order
        push_bits(64'(len), 8);
    endtask

    task automatic push_frame(input logic [39:0] w, input bit start, input bit flip, input bit stop);
        sq.push_back(start);
        push_bits({24'h0, w}, 40);
        sq.push_back((^w) ^ flip);
        sq.push_back(stop);
    endtask

    task automatic do_reset();
        chk_on = 0;
        RST = 1'b1; DIN_EN = 1'b0; DIN = 1'b1;
        @(posedge K);
        #1;
        RST = 1'b0;
        m = 0; last_idx = -1; stb_cnt = 0;
        sq.delete();
    endtask

    task automatic run(input bit toggle, input int limit);
        int p;
        bit ph;
        p = 0; ph = 1;
        analyze();
        chk_on = 1;
        while (p < limit) begin
            if (toggle) begin DIN_EN = ph; ph = !ph; end
            else DIN_EN = 1'b1;
            DIN = DIN_EN ? sq[p] : 1'($urandom_range(0, 1));
            @(posedge K);
            if (DIN_EN) begin last_idx = m; m++; p++; end
            else last_idx = -1;
            #1;
        end
        DIN_EN = 1'b0;
        repeat (4) begin
            @(posedge K);
            last_idx = -1;
            #1;
        end
    endtask

    // Per-cycle comparison against the positional prediction
    always @(negedge K) begin
        int na;
        bit e_stb, e_err, e_done, e_busy;
        if (chk_on) begin
            na = 0; e_stb = 0;
            foreach (acc_idx[i]) begin
                if (acc_idx[i] < m) na++;
                if (acc_idx[i] == last_idx) e_stb = 1;
            end
            e_err  = (fail_idx < m);
            e_done = (done_idx < m);
            e_busy = (m > i0) && !e_err && !e_done;
            chk("cfg_word", 64'(CFG_WORD), na > 0 ? 64'(acc_word[na - 1]) : 64'h0);
            chk("cfg_addr", 64'(CFG_ADDR), na > 0 ? 64'(na - 1) : 64'h0);
            chk("cfg_stb", 64'(CFG_STB), 64'(e_stb));
            chk("busy", 64'(BUSY), 64'(e_busy));
            chk("done", 64'(DONE), 64'(e_done));
            chk("err", 64'(ERR), 64'(e_err));
            chk("err_code", 64'(ERR_CODE), e_err ? 64'(fail_code) : 64'h0);
            if (CFG_STB) stb_cnt++;
        end
    end

    initial begin
        m = 0; last_idx = -1;

        // Reset state
        do_reset();
        @(negedge K);
        chk("rst_word", 64'(CFG_WORD), 64'h0);
        chk("rst_busy_done_err", {61'h0, BUSY, DONE, ERR}, 64'h0);
        chk("rst_code", 64'(ERR_CODE), 64'h0);

        // Single frame, continuous enable
        push_header(2, 1);
        push_frame(40'h00_0000_E8E8, 0, 0, 1);
        analyze();
        chk("model_word0", 64'(acc_word[0]), 64'h00_0000_E8E8);
        chk("model_done_idx", 64'(done_idx), 64'(2 + 12 + 42));
        run(0, sq.size());
        chk("t1_word", 64'(CFG_WORD), 64'h00_0000_E8E8);
        chk("t1_flags", {60'h0, DONE, BUSY, ERR, CFG_STB}, 64'b1000);
        chk("t1_strobes", 64'(stb_cnt), 64'd1);

        // Three frames, DIN_EN toggling, random trailing bits
        do_reset();
        push_header(1, 3);
        push_frame(40'h12_4A55_AA0F, 0, 0, 1);
        push_frame(40'h00_0000_FFFF, 0, 0, 1);
        push_frame(40'h00_0000_FF00, 0, 0, 1);
        for (int i = 0; i < 10; i++) sq.push_back(1'($urandom_range(0, 1)));
        analyze();
        chk("model_acc3", 64'(acc_idx.size()), 64'd3);
        run(1, sq.size());
        chk("t2_strobes", 64'(stb_cnt), 64'd3);
        chk("t2_addr", 64'(CFG_ADDR), 64'd2);
        chk("t2_word", 64'(CFG_WORD), 64'h00_0000_FF00);
        chk("t2_done", 64'(DONE), 64'd1);

        // Bad preamble
        do_reset();
        sq.push_back(1); sq.push_back(0); sq.push_back(1); sq.push_back(0); sq.push_back(0);
        run(0, sq.size());
        chk("t3_code", {60'h0, ERR, ERR_CODE}, 64'b1001);
        chk("t3_busy", 64'(BUSY), 64'd0);

        // Length zero and length one past the limit
        do_reset();
        push_header(0, 0);
        push_frame(40'h0, 0, 0, 1);
        run(0, sq.size());
        chk("t4_code", 64'(ERR_CODE), 64'd2);

        do_reset();
        push_header(3, NF + 1);
        push_frame(40'h0, 0, 0, 1);
        run(0, sq.size());
        chk("t5_code", 64'(ERR_CODE), 64'd2);

        // Length exactly at the limit is accepted (stream left partial)
        do_reset();
        push_header(0, NF);
        push_frame(40'h00_0000_1234, 0, 0, 1);
        run(0, sq.size());
        chk("t6_busy_err", {62'h0, BUSY, ERR}, 64'b10);
        chk("t6_strobes", 64'(stb_cnt), 64'd1);

        // Parity error on second frame: word keeps first frame's value
        do_reset();
        push_header(1, 2);
        push_frame(40'h00_0000_00A5, 0, 0, 1);
        push_frame(40'h00_0000_5A00, 0, 1, 1);
        run(0, sq.size());
        chk("t7_code", 64'(ERR_CODE), 64'd4);
        chk("t7_word", 64'(CFG_WORD), 64'h00_0000_00A5);
        chk("t7_strobes", 64'(stb_cnt), 64'd1);

        // Start bit 1, then stop bit 0
        do_reset();
        push_header(1, 1);
        push_frame(40'h00_0000_0001, 1, 0, 1);
        run(0, sq.size());
        chk("t8_code", 64'(ERR_CODE), 64'd3);

        do_reset();
        push_header(1, 1);
        push_frame(40'h00_0000_0003, 0, 0, 0);
        run(0, sq.size());
        chk("t9_code", 64'(ERR_CODE), 64'd3);
        chk("t9_strobes", 64'(stb_cnt), 64'd0);

        // Illegal X_OUT encoding with correct parity
        do_reset();
        push_header(1, 1);
        push_frame(40'h00_0600_0000, 0, 0, 1);
        run(0, sq.size());
        chk("t10_code", 64'(ERR_CODE), 64'd5);
        chk("t10_strobes", 64'(stb_cnt), 64'd0);

        // Reset mid-frame, then a clean two-frame load
        do_reset();
        push_header(1, 2);
        push_frame(40'h00_0000_0F0F, 0, 0, 1);
        sq.push_back(0);
        push_bits(64'hFFFFF, 20);
        run(0, sq.size());
        do_reset();
        @(negedge K);
        chk("t11_rst_word_addr", {CFG_WORD, CFG_ADDR}, 64'h0);
        chk("t11_rst_flags", {58'h0, CFG_STB, BUSY, DONE, ERR, ERR_CODE}, 64'h0);
        push_header(2, 2);
        push_frame(40'h00_0000_3C3C, 0, 0, 1);
        push_frame(40'h00_0000_C3C3, 0, 0, 1);
        run(0, sq.size());
        chk("t11_strobes", 64'(stb_cnt), 64'd2);
        chk("t11_addr", 64'(CFG_ADDR), 64'd1);
        chk("t11_done", {62'h0, DONE, ERR}, 64'b10);

        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
